// File: rtl/tour_cmd_sequencer_pkg.sv
// Shared types and constants for the Knight command sequencer and anything that drives it.
// Command words are {opcode[3:0], heading[7:0], squares[3:0]} for moves.
package tour_cmd_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_SNT,
      WAIT_RESP,
      HALT
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_NAK     = 2'd1;
   localparam logic [1:0] ERR_SNT_TO  = 2'd2;
   localparam logic [1:0] ERR_RESP_TO = 2'd3;

   localparam logic [15:0] CAL_GYRO  = 16'h2000;
   localparam logic [3:0]  OPC_MOVE  = 4'h4;
   localparam logic [3:0]  OPC_FANF  = 4'h5;
   localparam logic [3:0]  OPC_TOUR  = 4'h6;

   localparam logic [7:0]  HDG_NORTH = 8'h00;
   localparam logic [7:0]  HDG_WEST  = 8'h3F;
   localparam logic [7:0]  HDG_SOUTH = 8'h7F;
   localparam logic [7:0]  HDG_EAST  = 8'hBF;

   localparam logic [7:0]  POS_ACK   = 8'hA5;

   function automatic logic [15:0] mk_move(input logic [7:0] hdg, input logic [3:0] sq);
      return {OPC_MOVE, hdg, sq};
   endfunction

   function automatic logic [15:0] mk_tour(input logic [3:0] x, input logic [3:0] y);
      return {OPC_TOUR, 4'h0, x, y};
   endfunction

endpackage

// File: rtl/tour_cmd_sequencer_fifo.sv
// Synchronous command FIFO; flush empties it in one clock and wins over a same-cycle write.
// A write while full is accepted only when a read frees a slot in the same cycle.
module cmd_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_rd;
   logic             do_wr;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == FULL_CNT);
   assign rd_data_o = mem_q[rd_ptr_q];
   assign do_rd     = rd_en_i && !empty_o && !flush_i;
   assign do_wr     = wr_en_i && (!full_o || do_rd) && !flush_i;

   always_ff @(posedge clk_i) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_rd) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Drains queued Knight commands into RemoteComm one at a time, checking each response byte.
// Halts on NAK or timeout; abort is deferred until the current handshake resolves.
module tour_cmd_sequencer
   import tour_cmd_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter logic [7:0]  ACK_BYTE     = 8'hA5,
   parameter int unsigned TIMEOUT_CLKS = 50000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [15:0] wr_cmd,
   input  logic        start,
   input  logic        abort,
   output logic [15:0] cmd,
   output logic        snd_cmd,
   input  logic        cmd_snt,
   input  logic        resp_rdy,
   input  logic [7:0]  resp,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [7:0]  cmds_acked,
   output logic        full,
   output logic        empty
);
   localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

   state_e        state_q;
   logic [15:0]   cmd_q;
   logic          snd_cmd_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic [1:0]    err_code_q;
   logic [7:0]    acked_q;
   logic          abort_q;
   logic [TW-1:0] tmo_q;

   logic [15:0]   fifo_data;
   logic          pop;
   logic          flush;
   logic          abort_pend;
   logic          tmo_hit;

   assign abort_pend = abort_q || abort;
   assign tmo_hit    = (tmo_q == TMO_LAST);

   cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk_i     (clk),
      .rst_i     (rst),
      .flush_i   (flush),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_cmd),
      .rd_en_i   (pop),
      .rd_data_o (fifo_data),
      .full_o    (full),
      .empty_o   (empty)
   );

   // FIFO pop/flush decisions are shared by the state register update below.
   always_comb begin
      pop   = 1'b0;
      flush = 1'b0;
      case (state_q)
         IDLE, HALT: begin
            if (abort) begin
               flush = 1'b1;
            end else if (start && !empty) begin
               pop = 1'b1;
            end
         end
         WAIT_SNT: begin
            if (!cmd_snt && tmo_hit && abort_pend) begin
               flush = 1'b1;
            end
         end
         WAIT_RESP: begin
            if (resp_rdy) begin
               if (abort_pend) begin
                  flush = 1'b1;
               end else if (resp == ACK_BYTE && !empty) begin
                  pop = 1'b1;
               end
            end else if (tmo_hit && abort_pend) begin
               flush = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         snd_cmd_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         acked_q    <= '0;
         abort_q    <= 1'b0;
         tmo_q      <= '0;
      end else begin
         snd_cmd_q <= 1'b0;
         if (abort) begin
            abort_q <= 1'b1;
         end
         case (state_q)
            IDLE, HALT: begin
               abort_q <= 1'b0;
               if (!flush && start) begin
                  if (pop) begin
                     cmd_q      <= fifo_data;
                     done_q     <= 1'b0;
                     err_q      <= 1'b0;
                     err_code_q <= ERR_NONE;
                     acked_q    <= '0;
                     busy_q     <= 1'b1;
                     state_q    <= SEND;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            SEND: begin
               snd_cmd_q <= 1'b1;
               tmo_q     <= '0;
               state_q   <= WAIT_SNT;
            end
            WAIT_SNT: begin
               if (cmd_snt) begin
                  tmo_q   <= '0;
                  state_q <= WAIT_RESP;
               end else if (tmo_hit) begin
                  busy_q  <= 1'b0;
                  abort_q <= 1'b0;
                  if (abort_pend) begin
                     done_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_SNT_TO;
                     state_q    <= HALT;
                  end
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            WAIT_RESP: begin
               if (resp_rdy) begin
                  // A pending abort swallows this response instead of advancing the run.
                  if (abort_pend) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b0;
                     abort_q <= 1'b0;
                     state_q <= IDLE;
                  end else if (resp == ACK_BYTE) begin
                     if (acked_q != 8'hFF) begin
                        acked_q <= acked_q + 8'd1;
                     end
                     if (pop) begin
                        cmd_q   <= fifo_data;
                        state_q <= SEND;
                     end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                     end
                  end else begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_NAK;
                     busy_q     <= 1'b0;
                     state_q    <= HALT;
                  end
               end else if (tmo_hit) begin
                  busy_q  <= 1'b0;
                  abort_q <= 1'b0;
                  if (abort_pend) begin
                     done_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_RESP_TO;
                     state_q    <= HALT;
                  end
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd        = cmd_q;
   assign snd_cmd    = snd_cmd_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign err_code   = err_code_q;
   assign cmds_acked = acked_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed bench: a behavioural RemoteComm responder plus a scoreboard of expected command words.
module tb_tour_cmd_sequencer;
   import tour_cmd_sequencer_pkg::*;

   localparam int unsigned TMO = 1000;

   logic        clk = 1'b0;
   logic        rst, wr_en, start, abort, cmd_snt, resp_rdy;
   logic [15:0] wr_cmd, cmd;
   logic [7:0]  resp, cmds_acked;
   logic        snd_cmd, busy, done, err, full, empty;
   logic [1:0]  err_code;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int snd_cnt = 0;
   int resp_cyc = 0;
   bit hold_snt = 1'b0, hold_resp = 1'b0, lat_armed = 1'b0, prev_snd = 1'b0;
   logic [15:0] sb[$];
   logic [7:0]  rq[$];
   logic [7:0]  rb;

   tour_cmd_sequencer #(
      .DEPTH        (16),
      .ACK_BYTE     (POS_ACK),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_cmd     (wr_cmd),
      .start      (start),
      .abort      (abort),
      .cmd        (cmd),
      .snd_cmd    (snd_cmd),
      .cmd_snt    (cmd_snt),
      .resp_rdy   (resp_rdy),
      .resp       (resp),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_code   (err_code),
      .cmds_acked (cmds_acked),
      .full       (full),
      .empty      (empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every snd_cmd must match the oldest expected command.
   always @(negedge clk) begin
      if (snd_cmd) begin
         snd_cnt++;
         chk("snd_one_cycle", {31'd0, prev_snd}, 32'd0);
         chk("sb_has_entry_at_snd", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            chk("snd_cmd_order", {16'd0, cmd}, {16'd0, sb.pop_front()});
         end
         if (lat_armed) begin
            chk("resp_to_snd_latency", cyc - resp_cyc, 32'd2);
            lat_armed = 1'b0;
         end
      end
      prev_snd = snd_cmd;
   end

   // RemoteComm stand-in: cmd_snt 100 clocks after snd_cmd, response 200 clocks later.
   initial begin
      cmd_snt  = 1'b0;
      resp_rdy = 1'b0;
      resp     = '0;
      forever begin
         @(negedge clk);
         if (snd_cmd && !hold_snt && !rst) begin
            rb = (rq.size() != 0) ? rq.pop_front() : POS_ACK;
            repeat (100) @(posedge clk);
            #1 cmd_snt = 1'b1;
            @(posedge clk);
            #1 cmd_snt = 1'b0;
            if (!hold_resp) begin
               repeat (199) @(posedge clk);
               #1;
               resp     = rb;
               resp_rdy = 1'b1;
               if (rb == POS_ACK) begin
                  lat_armed = 1'b1;
                  resp_cyc  = cyc;
               end
               @(posedge clk);
               #1 resp_rdy = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [15:0] c, input bit accept);
      wr_en  = 1'b1;
      wr_cmd = c;
      if (accept) sb.push_back(c);
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      lat_armed = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n = 0;
      while (busy && n < max) begin
         @(posedge clk);
         #1 n++;
      end
      chk(tag, {31'd0, n < max}, 32'd1);
   endtask

   task automatic wait_snd(input string tag, input int max);
      int n = 0;
      while (!snd_cmd && n < max) begin
         @(posedge clk);
         #1 n++;
      end
      chk(tag, {31'd0, n < max}, 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd"},   {16'd0, cmd}, 32'd0);
      chk({tag, "_snd"},   {31'd0, snd_cmd}, 32'd0);
      chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
      chk({tag, "_done"},  {31'd0, done}, 32'd0);
      chk({tag, "_err"},   {31'd0, err}, 32'd0);
      chk({tag, "_code"},  {30'd0, err_code}, 32'd0);
      chk({tag, "_acked"}, {24'd0, cmds_acked}, 32'd0);
      chk({tag, "_full"},  {31'd0, full}, 32'd0);
      chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
   endtask

   initial begin
      int c0, c1, n, base;
      rst = 1'b1; wr_en = 1'b0; wr_cmd = '0; start = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_reset_outputs("reset");

      // 1: two commands, both acked
      push(CAL_GYRO, 1'b1);
      push(mk_move(HDG_NORTH, 4'd1), 1'b1);
      chk("t1_not_empty", {31'd0, empty}, 32'd0);
      pulse_start();
      chk("t1_busy", {31'd0, busy}, 32'd1);
      wait_idle("t1_bound", 2000);
      chk("t1_acked", {24'd0, cmds_acked}, 32'd2);
      chk("t1_done", {31'd0, done}, 32'd1);
      chk("t1_empty", {31'd0, empty}, 32'd1);
      chk("t1_err", {31'd0, err}, 32'd0);
      chk("t1_sb_drained", sb.size(), 32'd0);

      // 2: NAK on second command halts with third still queued
      rq.push_back(POS_ACK);
      rq.push_back(8'h5A);
      push(mk_move(HDG_EAST, 4'd2), 1'b1);
      push(mk_move(HDG_SOUTH, 4'd1), 1'b1);
      push(mk_tour(4'd2, 4'd2), 1'b1);
      pulse_start();
      wait_idle("t2_bound", 2000);
      chk("t2_err", {31'd0, err}, 32'd1);
      chk("t2_code", {30'd0, err_code}, {30'd0, ERR_NAK});
      chk("t2_acked", {24'd0, cmds_acked}, 32'd1);
      chk("t2_empty", {31'd0, empty}, 32'd0);
      chk("t2_unsent", sb.size(), 32'd1);
      pulse_abort();
      chk("t2_halt_flush", {31'd0, empty}, 32'd1);
      chk("t2_err_kept", {31'd0, err}, 32'd1);
      sb.delete();

      // 3: cmd_snt timeout, then response timeout
      hold_snt = 1'b1;
      push(mk_move(HDG_WEST, 4'd3), 1'b1);
      pulse_start();
      chk("t3_err_cleared", {31'd0, err}, 32'd0);
      wait_snd("t3_snd_bound", 50);
      c0 = cyc;
      n = 0;
      while (!err && n < 2000) begin
         @(posedge clk);
         #1 n++;
      end
      c1 = cyc;
      chk("t3_snt_to_delay", c1 - c0, TMO);
      chk("t3_snt_code", {30'd0, err_code}, {30'd0, ERR_SNT_TO});
      chk("t3_snt_busy", {31'd0, busy}, 32'd0);
      hold_snt  = 1'b0;
      hold_resp = 1'b1;
      push(mk_move(HDG_NORTH, 4'd2), 1'b1);
      pulse_start();
      wait_idle("t3_resp_bound", 3000);
      chk("t3_resp_err", {31'd0, err}, 32'd1);
      chk("t3_resp_code", {30'd0, err_code}, {30'd0, ERR_RESP_TO});
      chk("t3_resp_acked", {24'd0, cmds_acked}, 32'd0);
      hold_resp = 1'b0;

      // 4: fill to 16, 17th dropped, full run
      for (int i = 0; i < 16; i++) begin
         push(16'h4000 + 16'(i), 1'b1);
      end
      chk("t4_full", {31'd0, full}, 32'd1);
      push(16'h5FFF, 1'b0);
      chk("t4_full_kept", {31'd0, full}, 32'd1);
      pulse_start();
      wait_idle("t4_bound", 8000);
      chk("t4_acked", {24'd0, cmds_acked}, 32'd16);
      chk("t4_done", {31'd0, done}, 32'd1);
      chk("t4_empty", {31'd0, empty}, 32'd1);
      chk("t4_full_clear", {31'd0, full}, 32'd0);
      chk("t4_sb_drained", sb.size(), 32'd0);

      // 5: abort during second command's response wait
      for (int i = 0; i < 4; i++) begin
         push(mk_move(HDG_EAST, 4'(i + 1)), 1'b1);
      end
      base = snd_cnt;
      pulse_start();
      n = 0;
      while (snd_cnt < base + 2 && n < 1000) begin
         @(posedge clk);
         #1 n++;
      end
      chk("t5_second_snd", snd_cnt - base, 32'd2);
      repeat (150) @(posedge clk);
      #1 pulse_abort();
      wait_idle("t5_bound", 1000);
      chk("t5_empty", {31'd0, empty}, 32'd1);
      chk("t5_done", {31'd0, done}, 32'd0);
      chk("t5_err", {31'd0, err}, 32'd0);
      chk("t5_acked", {24'd0, cmds_acked}, 32'd1);
      repeat (400) @(posedge clk);
      #1 chk("t5_no_more_snd", snd_cnt - base, 32'd2);
      sb.delete();

      // 6: reset mid-sequence, then start on empty FIFO
      hold_snt = 1'b1;
      push(mk_tour(4'd1, 4'd3), 1'b1);
      push(CAL_GYRO, 1'b1);
      pulse_start();
      wait_snd("t6_snd_bound", 50);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 chk_reset_outputs("t6_rst");
      rst = 1'b0;
      sb.delete();
      hold_snt = 1'b0;
      base = snd_cnt;
      pulse_start();
      chk("t6_done_empty", {31'd0, done}, 32'd1);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      repeat (20) @(posedge clk);
      #1 chk("t6_no_snd", snd_cnt - base, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tour_cmd_sequencer.md
Name: tour_cmd_sequencer

Overview:
- Queues 16-bit Knight commands and issues them one at a time to the RemoteComm transmitter via its snd_cmd/cmd_snt handshake.
- Sits directly upstream of RemoteComm in the system-level bench/host side.
- Waits for the 8-bit response from RemoteComm after each command, and checks it against the positive-acknowledge byte before issuing the next command.
- Flags NAKs and timeouts, and halts on the first error.

Parameters:
- DEPTH, 16: command FIFO depth in entries; must be a power of 2.
- ACK_BYTE, 8'hA5: response value treated as positive acknowledge.
- TIMEOUT_CLKS, 50000000: clocks allowed per phase (cmd_snt wait or resp wait); counter width is $clog2(TIMEOUT_CLKS+1).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  push wr_cmd into FIFO.
- wr_cmd  in  16  command word (e.g. 16'h2000 cal, 16'h4001 move north 1).
- start  in  1  one-cycle pulse; begin draining FIFO.
- abort  in  1  one-cycle pulse; stop after current handshake, flush FIFO.
- cmd  out  16  command presented to RemoteComm.
- snd_cmd  out  1  one-cycle send strobe to RemoteComm.
- cmd_snt  in  1  RemoteComm finished transmitting both bytes.
- resp_rdy  in  1  response byte valid (one-cycle pulse).
- resp  in  8  response byte.
- busy  out  1  sequence in progress.
- done  out  1  sticky, all queued commands acked.
- err  out  1  sticky error.
- err_code  out  2  0 none, 1 NAK, 2 cmd_snt timeout, 3 resp timeout.
- cmds_acked  out  8  count of positively acked commands (saturates at 255).
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.

Behaviour:
- Reset outputs:
  - cmd=0, snd_cmd=0, busy=0, done=0, err=0, err_code=0, cmds_acked=0, full=0, empty=1.
  - FIFO pointers cleared; state=IDLE.
- FIFO:
  - wr_en while full is dropped; contents are unchanged.
  - Writes are allowed in any state, including while busy; appended commands are issued in the same run.
  - Simultaneous push and pop while full: pop occurs and the push is accepted.
- IDLE:
  - start with FIFO non-empty: pop head into cmd register, clear done/err/err_code/cmds_acked, go to SEND.
  - start with FIFO empty: done=1 the next cycle, stay IDLE.
- SEND:
  - snd_cmd=1 for exactly one cycle with cmd stable.
  - Next state WAIT_SNT; timeout counter cleared.
- WAIT_SNT:
  - cmd held stable.
  - On cmd_snt, go to WAIT_RESP with counter cleared.
  - Counter reaching TIMEOUT_CLKS: err=1, err_code=2, go to HALT.
  - resp_rdy arriving here is ignored.
- WAIT_RESP:
  - On resp_rdy with resp==ACK_BYTE: cmds_acked++ (saturating).
    - FIFO non-empty: pop the next command, go to SEND.
    - FIFO empty: done=1, go to IDLE.
  - On resp_rdy with resp!=ACK_BYTE: err=1, err_code=1, go to HALT.
  - Timeout: err_code=3, go to HALT.
  - Latency from resp_rdy to the next snd_cmd is 2 clocks.
- HALT:
  - busy=0; remaining FIFO contents retained.
  - start re-enters as in IDLE but does not clear the FIFO.
- busy=1 in SEND, WAIT_SNT and WAIT_RESP.
- abort:
  - Sets a pending flag.
  - In WAIT_RESP, the next resp_rdy is consumed and the flag acts instead of advancing: FIFO flushed, go to IDLE, done=0, err unchanged.
  - In IDLE or HALT: immediate flush.
  - A timeout also resolves a pending abort the same way, without setting err.
- rst asserted mid-sequence: all state returns to reset values next edge; snd_cmd never remains high.

Decomposition:
- Shared package gets:
  - state enum (IDLE, SEND, WAIT_SNT, WAIT_RESP, HALT);
  - err_code localparams;
  - command constants (CAL_GYRO=16'h2000, move/tour opcodes) and POS_ACK=8'hA5, usable by tb tasks.
- One sub-module, cmd_fifo (synchronous FIFO with wr/rd/full/empty, DEPTH param).
- The FSM and timeout counter live in the top.

Test Plan:
1. Push 16'h2000 and 16'h4001, start; responder returns cmd_snt after 100 clocks and resp=8'hA5 after 200 clocks each -> two snd_cmd pulses with cmd matching in order, cmds_acked=2, done=1, busy=0, empty=1.
2. Push 3 commands, second response 8'h5A -> err=1, err_code=1, cmds_acked=1, third command not sent, empty=0.
3. Push 1 command, withhold cmd_snt with TIMEOUT_CLKS=1000 -> err_code=2 exactly 1000 clocks after entering WAIT_SNT; then withhold resp only -> err_code=3.
4. Push 17 commands with DEPTH=16 -> full=1 after 16, 17th dropped; full run gives cmds_acked=16.
5. abort during the second command's WAIT_RESP with 4 queued -> after its resp_rdy: state IDLE, empty=1, done=0, err=0, no further snd_cmd.
6. Assert rst during WAIT_SNT -> next cycle all outputs at reset values; start with empty FIFO -> done=1 one cycle later, no snd_cmd.
